// File: rtl/mor1kx_icache_refill_engine.sv
// Icache refill bus master: fetches one cache line as a Wishbone B3 wrapping
// burst, critical word first, and streams each returned word into the cache.
module mor1kx_icache_refill_engine #(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            refill_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
  output logic                            we_o,
  output logic                            imem_err_o,
  output logic                            busy_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic [2:0]                      wbm_cti_o,
  output logic [1:0]                      wbm_bte_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i
);

  localparam int AW      = OPTION_OPERAND_WIDTH;
  localparam int BW      = OPTION_ICACHE_BLOCK_WIDTH;
  localparam int WORDS_W = BW - 2;
  localparam int N       = 1 << WORDS_W;
  localparam logic [WORDS_W-1:0] CNT_PEN  = WORDS_W'(N - 2);
  localparam logic [WORDS_W-1:0] CNT_LAST = WORDS_W'(N - 1);
  localparam logic [1:0] BTE_WRAP = (BW == 4) ? 2'b01 : 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      adr_q, adr_d;
  logic               cyc_q, cyc_d;
  logic [2:0]         cti_q, cti_d;
  logic [1:0]         bte_q, bte_d;
  logic [WORDS_W-1:0] cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [AW-1:0]      wradr_q, wradr_d;
  logic [AW-1:0]      wrdat_q, wrdat_d;
  logic               err_q, err_d;

  // Byte offset within the critical word is irrelevant to a word-wide bus.
  logic unused_adr_lsb;
  assign unused_adr_lsb = &{1'b0, refill_adr_i[1:0]};

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cyc_d   = cyc_q;
    cti_d   = cti_q;
    bte_d   = bte_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wradr_d = wradr_q;
    wrdat_d = wrdat_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (refill_req_i) begin
          state_d = ST_BURST;
          adr_d   = {refill_adr_i[AW-1:2], 2'b00};
          cyc_d   = 1'b1;
          cti_d   = 3'b010;
          bte_d   = BTE_WRAP;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        // Error wins over a same-cycle ack: the faulting word is never written.
        if (wbm_err_i) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          cti_d   = 3'b000;
          bte_d   = 2'b00;
          err_d   = 1'b1;
        end else if (wbm_ack_i) begin
          we_d    = 1'b1;
          wradr_d = adr_q;
          wrdat_d = wbm_dat_i;
          adr_d[BW-1:2] = adr_q[BW-1:2] + WORDS_W'(1);
          cnt_d   = cnt_q + WORDS_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FLUSH;
            cyc_d   = 1'b0;
            cti_d   = 3'b000;
            bte_d   = 2'b00;
          end else if (cnt_q == CNT_PEN) begin
            cti_d   = 3'b111;
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= 3'b000;
      bte_q   <= 2'b00;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wradr_q <= '0;
      wrdat_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cyc_q   <= cyc_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wradr_q <= wradr_d;
      wrdat_q <= wrdat_d;
      err_q   <= err_d;
    end
  end

  assign wradr_o    = wradr_q;
  assign wrdat_o    = wrdat_q;
  assign we_o       = we_q;
  assign imem_err_o = err_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign wbm_adr_o  = adr_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_cti_o  = cti_q;
  assign wbm_bte_o  = bte_q;

endmodule

// File: tb/tb_mor1kx_icache_refill_engine.sv
// Directed bench for the icache refill engine: 8-word and 4-word line instances,
// expected cache writes queued as beats are acked and checked as they emerge.
module tb_mor1kx_icache_refill_engine;

  logic        clk, rst_n;
  logic        req5, req4;
  logic [31:0] refill_adr, bus_dat;
  logic        bus_ack, bus_err;

  logic [31:0] wradr5, wrdat5, adr5, wradr4, wrdat4, adr4;
  logic        we5, ierr5, busy5, cyc5, stb5, we4, ierr4, busy4, cyc4, stb4;
  logic [2:0]  cti5, cti4;
  logic [1:0]  bte5, bte4;

  mor1kx_icache_refill_engine #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)) u5 (
    .clk(clk), .rst_n(rst_n), .refill_req_i(req5), .refill_adr_i(refill_adr),
    .wradr_o(wradr5), .wrdat_o(wrdat5), .we_o(we5), .imem_err_o(ierr5), .busy_o(busy5),
    .wbm_adr_o(adr5), .wbm_cyc_o(cyc5), .wbm_stb_o(stb5), .wbm_cti_o(cti5), .wbm_bte_o(bte5),
    .wbm_dat_i(bus_dat), .wbm_ack_i(bus_ack), .wbm_err_i(bus_err));

  mor1kx_icache_refill_engine #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .refill_req_i(req4), .refill_adr_i(refill_adr),
    .wradr_o(wradr4), .wrdat_o(wrdat4), .we_o(we4), .imem_err_o(ierr4), .busy_o(busy4),
    .wbm_adr_o(adr4), .wbm_cyc_o(cyc4), .wbm_stb_o(stb4), .wbm_cti_o(cti4), .wbm_bte_o(bte4),
    .wbm_dat_i(bus_dat), .wbm_ack_i(bus_ack), .wbm_err_i(bus_err));

  // Observed-instance select: 0 = 8-word line, 1 = 4-word line
  logic        sel;
  logic [31:0] wradr, wrdat, wadr;
  logic        we, ierr, busy, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  assign wradr = sel ? wradr4 : wradr5;
  assign wrdat = sel ? wrdat4 : wrdat5;
  assign wadr  = sel ? adr4   : adr5;
  assign we    = sel ? we4    : we5;
  assign ierr  = sel ? ierr4  : ierr5;
  assign busy  = sel ? busy4  : busy5;
  assign cyc   = sel ? cyc4   : cyc5;
  assign stb   = sel ? stb4   : stb5;
  assign cti   = sel ? cti4   : cti5;
  assign bte   = sel ? bte4   : bte5;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Scoreboard consumer: every cache write must match the oldest queued beat.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (sb.size() == 0) chk("spurious_we", 32'd1, 32'd0);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("wradr", wradr, e[63:32]);
        chk("wrdat", wrdat, e[31:0]);
      end
    end
  end

  task automatic burst(input bit s4, input logic [31:0] a, input bit gap,
                       input int err_b, input bit hold, input int rst_b);
    int n;
    logic [31:0] base, ea;
    n = s4 ? 4 : 8;
    sel = s4;
    base = a & ~32'(n * 4 - 1);
    refill_adr = a;
    if (s4) req4 = 1'b1; else req5 = 1'b1;
    @(negedge clk);
    chk("busy_start", {31'd0, busy}, 32'd1);
    for (int b = 0; b < n; b++) begin
      ea = base | (32'(((a >> 2) + 32'(b)) % 32'(n)) << 2);
      if (gap && b > 0) begin
        bus_ack = 1'b0;
        @(negedge clk);
        chk("we_gap", {31'd0, we}, 32'd0);
        chk("adr_gap", wadr, ea);
      end
      if (b == rst_b) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_cyc", {30'd0, cyc, stb}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wradr", wradr, 32'd0);
        chk("rst_wrdat", wrdat, 32'd0);
        chk("rst_adr", wadr, 32'd0);
        chk("rst_cti_bte", {27'd0, cti, bte}, 32'd0);
        req5 = 1'b0; req4 = 1'b0;
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_cyc", {31'd0, cyc}, 32'd0);
        return;
      end
      chk("cyc_stb", {30'd0, cyc, stb}, 32'd3);
      chk("wbm_adr", wadr, ea);
      chk("cti", {29'd0, cti}, (b == n - 1) ? 32'd7 : 32'd2);
      chk("bte", {30'd0, bte}, s4 ? 32'd1 : 32'd2);
      bus_ack = 1'b1;
      bus_err = (b == err_b);
      bus_dat = mem(ea);
      if (b != err_b) sb.push_back({ea, mem(ea)});
      @(negedge clk);
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (b == 0 && !hold) begin req5 = 1'b0; req4 = 1'b0; end
      if (b == err_b) begin
        chk("err_pulse", {31'd0, ierr}, 32'd1);
        chk("err_cyc", {31'd0, cyc}, 32'd0);
        chk("err_busy", {31'd0, busy}, 32'd0);
        chk("err_we", {31'd0, we}, 32'd0);
        @(negedge clk);
        chk("err_pulse_end", {31'd0, ierr}, 32'd0);
        chk("err_writes", 32'(sb.size()), 32'd0);
        return;
      end
    end
    chk("end_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    chk("end_cti", {29'd0, cti}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_cyc", {31'd0, cyc}, 32'd0);
    chk("line_writes", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    req5 = 1'b0; req4 = 1'b0;
    refill_adr = '0; bus_dat = '0; bus_ack = 1'b0; bus_err = 1'b0;
    #3;
    chk("reset_outs", {23'd0, we, ierr, busy, cyc, stb, cti, bte}, 32'd0);
    chk("reset_adr", wadr | wradr | wrdat, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", {31'd0, busy}, 32'd0);

    burst(1'b0, 32'h0000_101C, 1'b0, -1, 1'b0, -1); // critical word last in line
    burst(1'b1, 32'h0000_2008, 1'b1, -1, 1'b0, -1); // 4-word, gapped acks
    burst(1'b0, 32'h0000_3004, 1'b0,  2, 1'b0, -1); // error on 3rd beat
    burst(1'b1, 32'h0000_2004, 1'b0, -1, 1'b1, -1); // request held through FLUSH
    burst(1'b1, 32'h0000_200C, 1'b0, -1, 1'b0, -1); // restarts at edge L+2
    burst(1'b0, 32'h0000_4010, 1'b0, -1, 1'b0,  4); // reset mid-burst
    burst(1'b0, 32'h0000_5000, 1'b0, -1, 1'b0, -1); // request dropped after beat 0

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
